// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the central register file: zero sweep after reset or
// on request, then round-robin sharing between core writeback (0) and debug/loader (1).
module regfile_write_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int PROTECT_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_writeAddr,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              grant_id,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {CLEAR, ARB} stateT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] sweepPtr;
  logic              rrPtr;
  logic              grant0;
  logic              grant1;
  logic              anyGrant;
  logic              winner;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;
  logic              suppressWrite;

  // Grants are only made in ARB and never in a cycle that requests a new sweep.
  always_comb begin
    stateNext = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      CLEAR: begin
        if (sweepPtr == LAST_ADDR) stateNext = ARB;
      end
      ARB: begin
        if (clear_req) begin
          stateNext = CLEAR;
        end else if (req0_valid && (!req1_valid || !rrPtr)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  assign anyGrant      = grant0 | grant1;
  assign winner        = grant1;
  assign winAddr       = grant1 ? req1_addr : req0_addr;
  assign winData       = grant1 ? req1_data : req0_data;
  assign suppressWrite = (PROTECT_R0 != 0) && (winAddr == '0);

  assign busy       = (state == CLEAR);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      sweepPtr <= '0;
      rrPtr    <= 1'b0;
    end else begin
      state    <= stateNext;
      // Held at zero outside CLEAR so every sweep starts from address 0.
      sweepPtr <= (state == CLEAR) ? sweepPtr + ADDR_W'(1) : '0;
      if (anyGrant) rrPtr <= ~winner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_regWrite  <= 1'b0;
      rf_writeAddr <= '0;
      rf_writeData <= '0;
      grant_id     <= 1'b0;
    end else if (state == CLEAR) begin
      rf_regWrite  <= 1'b1;
      rf_writeAddr <= sweepPtr;
      rf_writeData <= '0;
    end else if (anyGrant) begin
      rf_regWrite  <= ~suppressWrite;
      rf_writeAddr <= winAddr;
      rf_writeData <= winData;
      grant_id     <= winner;
    end else begin
      rf_regWrite  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (state == ARB && req0_valid && req1_valid && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued as stimulus
// is driven and retired when the register-file write port shows them.
module tb_regfile_write_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              id;
    bit                checkId;
  } expWriteT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clearReq = 1'b0;
  logic              req0Valid = 1'b0;
  logic [ADDR_W-1:0] req0Addr = '0;
  logic [DATA_W-1:0] req0Data = '0;
  logic              req1Valid = 1'b0;
  logic [ADDR_W-1:0] req1Addr = '0;
  logic [DATA_W-1:0] req1Data = '0;

  logic              busy, req0Ready, req1Ready, rfRegWrite, grantId;
  logic [ADDR_W-1:0] rfWriteAddr;
  logic [DATA_W-1:0] rfWriteData;
  logic [7:0]        conflictCnt;

  logic              busyP, req0ReadyP, req1ReadyP, rfRegWriteP, grantIdP;
  logic [ADDR_W-1:0] rfWriteAddrP;
  logic [DATA_W-1:0] rfWriteDataP;
  logic [7:0]        conflictCntP;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PROTECT_R0(0)) dut (
    .clk(clk), .rst(rst), .clear_req(clearReq), .busy(busy),
    .req0_valid(req0Valid), .req0_addr(req0Addr), .req0_data(req0Data), .req0_ready(req0Ready),
    .req1_valid(req1Valid), .req1_addr(req1Addr), .req1_data(req1Data), .req1_ready(req1Ready),
    .rf_regWrite(rfRegWrite), .rf_writeAddr(rfWriteAddr), .rf_writeData(rfWriteData),
    .grant_id(grantId), .conflict_cnt(conflictCnt)
  );

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PROTECT_R0(1)) dutP (
    .clk(clk), .rst(rst), .clear_req(clearReq), .busy(busyP),
    .req0_valid(req0Valid), .req0_addr(req0Addr), .req0_data(req0Data), .req0_ready(req0ReadyP),
    .req1_valid(req1Valid), .req1_addr(req1Addr), .req1_data(req1Data), .req1_ready(req1ReadyP),
    .rf_regWrite(rfRegWriteP), .rf_writeAddr(rfWriteAddrP), .rf_writeData(rfWriteDataP),
    .grant_id(grantIdP), .conflict_cnt(conflictCntP)
  );

  always #5 clk = ~clk;

  expWriteT          sbq[$];
  expWriteT          monExp;
  int                checkCount = 0;
  int                passCount  = 0;
  logic              expRr = 1'b0;
  int                expConf = 0;
  int                n;
  logic [DATA_W-1:0] rfModel  [NUM_REGS];
  logic [DATA_W-1:0] rfModelP [NUM_REGS];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    clearReq  = 1'b0;
  endtask

  task automatic pushSweep();
    for (int i = 0; i < NUM_REGS; i++)
      sbq.push_back('{addr: ADDR_W'(i), data: '0, id: 1'b0, checkId: 1'b0});
  endtask

  // One ARB cycle: drive both requesters, check readies against the round-robin model.
  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    logic e0, e1;
    req0Valid = v0; req0Addr = a0; req0Data = d0;
    req1Valid = v1; req1Addr = a1; req1Data = d1;
    #2;
    e0 = v0 && (!v1 || !expRr);
    e1 = v1 && !e0;
    checkOutput("ready0", 64'(req0Ready), 64'(e0));
    checkOutput("ready1", 64'(req1Ready), 64'(e1));
    if (e0 || e1) begin
      sbq.push_back('{addr: e1 ? a1 : a0, data: e1 ? d1 : d0, id: e1, checkId: 1'b1});
      expRr = !e1;
    end
    if (v0 && v1 && expConf < 255) expConf++;
    waitCycle();
  endtask

  task automatic waitSweep(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      waitCycle();
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < NUM_REGS; i++) checkOutput(tag, 64'(rfModel[i]), 64'd0);
  endtask

  // Behavioural register files write on the negedge, as the real one does.
  always @(negedge clk) begin
    if (rfRegWrite)  rfModel[rfWriteAddr]   <= rfWriteData;
    if (rfRegWriteP) rfModelP[rfWriteAddrP] <= rfWriteDataP;
  end

  always @(negedge clk) begin
    if (rst && rfRegWrite) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious write", 64'(sbq.size()), 64'd1);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("wr addr", 64'(rfWriteAddr), 64'(monExp.addr));
        checkOutput("wr data", 64'(rfWriteData), 64'(monExp.data));
        if (monExp.checkId) checkOutput("grant_id", 64'(grantId), 64'(monExp.id));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rfModel[i]  = 32'hA5A5_A5A5;
      rfModelP[i] = 32'hA5A5_A5A5;
    end
    #1;
    rst = 1'b0;
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    #2;
    checkOutput("rst busy", 64'(busy), 64'd1);
    checkOutput("rst regWrite", 64'(rfRegWrite), 64'd0);
    checkOutput("rst addr", 64'(rfWriteAddr), 64'd0);
    checkOutput("rst data", 64'(rfWriteData), 64'd0);
    checkOutput("rst grant", 64'(grantId), 64'd0);
    checkOutput("rst conflict", 64'(conflictCnt), 64'd0);
    checkOutput("rst ready0", 64'(req0Ready), 64'd0);
    checkOutput("rst ready1", 64'(req1Ready), 64'd0);
    waitCycle();
    idle();
    waitCycle();

    // Power-on sweep.
    pushSweep();
    rst = 1'b1;
    waitSweep(n);
    checkOutput("sweep length", 64'(n), 64'd32);
    waitCycle();
    checkOutput("sweep drop", 64'(rfRegWrite), 64'd0);
    checkOutput("sweep drained", 64'(sbq.size()), 64'd0);
    checkAllZero("sweep reg");

    // Single requester 0.
    applyStimulus(1'b1, 5'd12, 32'hDEAD_BEEF, 1'b0, '0, '0);
    idle();
    checkOutput("single regWrite", 64'(rfRegWrite), 64'd1);
    waitCycle();
    checkOutput("reg12", 64'(rfModel[12]), 64'hDEAD_BEEF);

    // Contention, then run conflict_cnt into saturation.
    repeat (4) applyStimulus(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
    checkOutput("conflict4", 64'(conflictCnt), 64'd4);
    repeat (255) applyStimulus(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
    checkOutput("conflict sat", 64'(conflictCnt), 64'd255);
    idle();
    waitCycle();
    checkOutput("contention drained", 64'(sbq.size()), 64'd0);

    // clear_req in ARB with requester 1 waiting; a second pulse mid-sweep is ignored.
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
    req0Valid = 1'b0;
    clearReq  = 1'b1;
    req1Valid = 1'b1; req1Addr = 5'd7; req1Data = 32'h77;
    #2;
    checkOutput("clr ready0", 64'(req0Ready), 64'd0);
    checkOutput("clr ready1", 64'(req1Ready), 64'd0);
    pushSweep();
    n = 0;
    while (req1Ready !== 1'b1 && n < 100) begin
      n++;
      waitCycle();
      clearReq = (n == 5);
      #2;
      if (n == 1) checkOutput("clr busy", 64'(busy), 64'd1);
    end
    checkOutput("hold length", 64'(n), 64'd33);
    sbq.push_back('{addr: 5'd7, data: 32'h77, id: 1'b1, checkId: 1'b1});
    expRr = 1'b0;
    waitCycle();
    idle();
    waitCycle();
    checkOutput("clr drained", 64'(sbq.size()), 64'd0);
    checkOutput("reg5 cleared", 64'(rfModel[5]), 64'd0);
    checkOutput("reg7", 64'(rfModel[7]), 64'h77);

    // Write to address 0: suppressed only by the protecting instance.
    req1Valid = 1'b1; req1Addr = 5'd0; req1Data = 32'hFFFF;
    #2;
    checkOutput("r0 ready1", 64'(req1Ready), 64'd1);
    checkOutput("r0 readyP1", 64'(req1ReadyP), 64'd1);
    sbq.push_back('{addr: 5'd0, data: 32'hFFFF, id: 1'b1, checkId: 1'b1});
    expRr = 1'b0;
    waitCycle();
    idle();
    checkOutput("r0 regWrite", 64'(rfRegWrite), 64'd1);
    checkOutput("r0 regWriteP", 64'(rfRegWriteP), 64'd0);
    waitCycle();
    checkOutput("reg0", 64'(rfModel[0]), 64'hFFFF);
    checkOutput("reg0 protected", 64'(rfModelP[0]), 64'd0);
    checkOutput("r0 drained", 64'(sbq.size()), 64'd0);

    // Reset in the middle of a sweep.
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b0, '0, '0);
    idle();
    waitCycle();
    checkOutput("reg20", 64'(rfModel[20]), 64'h20);
    clearReq = 1'b1;
    pushSweep();
    waitCycle();
    clearReq = 1'b0;
    n = 0;
    while (!(rfRegWrite && rfWriteAddr == 5'd10) && n < 100) begin
      n++;
      waitCycle();
    end
    checkOutput("reach addr10", 64'(n < 100), 64'd1);
    rst = 1'b0;
    #2;
    checkOutput("abort regWrite", 64'(rfRegWrite), 64'd0);
    checkOutput("abort addr", 64'(rfWriteAddr), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd1);
    checkOutput("abort conflict", 64'(conflictCnt), 64'd0);
    sbq.delete();
    expRr   = 1'b0;
    expConf = 0;
    repeat (2) waitCycle();
    pushSweep();
    rst = 1'b1;
    waitSweep(n);
    checkOutput("restart length", 64'(n), 64'd32);
    waitCycle();
    checkOutput("restart drained", 64'(sbq.size()), 64'd0);
    checkAllZero("restart reg");

    // Round-robin pointer is back to requester 0 after reset.
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    idle();
    waitCycle();
    checkOutput("final drained", 64'(sbq.size()), 64'd0);
    checkOutput("reg1", 64'(rfModel[1]), 64'h11);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
